// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// State encoding is fixed at two bits so it can be probed on legacy debug buses.
package mem_arb_pkg;

    localparam int          TIMEOUT_CYC_DEF = 16;
    localparam logic [31:0] ABORT_DATA      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_IF_WAIT = 2'b01,
        ST_DM_WAIT = 2'b10,
        ST_DONE    = 2'b11
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and single-port memory signals of the arbiter.
// The master modport is the arbiter itself; slave is the CPU/memory environment.
interface mem_arbiter_if;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;

    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic        dm_ack_o;
    logic [31:0] dm_rdata_o;

    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;

    logic        stall_o;
    logic        err_o;

    modport master (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ready_i,
        output if_ack_o, if_rdata_o,
        output dm_ack_o, dm_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ready_i,
        input  if_ack_o, if_rdata_o,
        input  dm_ack_o, dm_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_o, err_o
    );

endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// Memory wait counter: cleared while idle, counts unanswered wait cycles,
// flags the last permitted cycle through tc.
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (enable && !tc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one memory port between fetch and data sides,
// with a per-transaction wait timeout.
//
//   state   | meaning
//   IDLE    | no transaction; grant data side first, then fetch
//   IF_WAIT | fetch command on memory port, waiting for ready
//   DM_WAIT | data command on memory port, waiting for ready
//   DONE    | one-cycle ack to owner (err if aborted), then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.master bus
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] IF_WAIT = ST_IF_WAIT;
    localparam logic [1:0] DM_WAIT = ST_DM_WAIT;
    localparam logic [1:0] DONE    = ST_DONE;

    logic [1:0]  state;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic        g_we;
    logic        g_dm;
    logic        aborted;
    logic [31:0] if_rdata;
    logic [31:0] dm_rdata;
    logic        wait_st;
    logic        tmo;

    assign wait_st = (state == IF_WAIT) || (state == DM_WAIT);

    wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (state == IDLE),
        .enable (wait_st && !bus.mem_ready_i),
        .tc     (tmo)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            g_addr   <= 32'd0;
            g_wdata  <= 32'd0;
            g_we     <= 1'b0;
            g_dm     <= 1'b0;
            aborted  <= 1'b0;
            if_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    if (bus.dm_req_i) begin
                        state   <= DM_WAIT;
                        g_dm    <= 1'b1;
                        g_addr  <= bus.dm_addr_i;
                        g_we    <= bus.dm_we_i;
                        g_wdata <= bus.dm_wdata_i;
                    end else if (bus.if_req_i) begin
                        state   <= IF_WAIT;
                        g_dm    <= 1'b0;
                        g_addr  <= bus.if_addr_i;
                        g_we    <= 1'b0;
                        g_wdata <= 32'd0;
                    end
                end
                IF_WAIT, DM_WAIT: begin
                    // Stores never touch dm_rdata, even when aborted.
                    if (bus.mem_ready_i || tmo) begin
                        state   <= DONE;
                        aborted <= !bus.mem_ready_i;
                        if (!g_dm) begin
                            if_rdata <= bus.mem_ready_i ? bus.mem_rdata_i : ABORT_DATA;
                        end else if (!g_we) begin
                            dm_rdata <= bus.mem_ready_i ? bus.mem_rdata_i : ABORT_DATA;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en_o    = wait_st;
    assign bus.mem_we_o    = g_we;
    assign bus.mem_addr_o  = g_addr;
    assign bus.mem_wdata_o = g_wdata;
    assign bus.if_ack_o    = (state == DONE) && !g_dm;
    assign bus.dm_ack_o    = (state == DONE) && g_dm;
    assign bus.err_o       = (state == DONE) && aborted;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.dm_rdata_o  = dm_rdata;
    assign bus.stall_o     = (bus.if_req_i && !bus.if_ack_o) || (bus.dm_req_i && !bus.dm_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, slow load, timeout abort,
// and asynchronous reset during a data wait.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    always #5 clk_sys = ~clk_sys;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk_i (clk_sys),
        .rst_i (rst_n),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic post_edge();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk_sys);
    endtask

    initial begin
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = 32'd0;
        bus.dm_req_i    = 1'b0;
        bus.dm_we_i     = 1'b0;
        bus.dm_addr_i   = 32'd0;
        bus.dm_wdata_i  = 32'd0;
        bus.mem_rdata_i = 32'd0;
        bus.mem_ready_i = 1'b0;

        // reset state
        #3;
        check_val("rst_if_ack",   32'(bus.if_ack_o), 32'd0);
        check_val("rst_dm_ack",   32'(bus.dm_ack_o), 32'd0);
        check_val("rst_mem_en",   32'(bus.mem_en_o), 32'd0);
        check_val("rst_mem_we",   32'(bus.mem_we_o), 32'd0);
        check_val("rst_mem_addr", bus.mem_addr_o,    32'd0);
        check_val("rst_mem_wd",   bus.mem_wdata_o,   32'd0);
        check_val("rst_if_rd",    bus.if_rdata_o,    32'd0);
        check_val("rst_dm_rd",    bus.dm_rdata_o,    32'd0);
        check_val("rst_err",      32'(bus.err_o),    32'd0);
        check_val("rst_stall",    32'(bus.stall_o),  32'd0);

        // fetch raised during reset: stall is combinational, no grant yet
        repeat (2) mid_cycle();
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0040;
        #1;
        check_val("rst_stall_req", 32'(bus.stall_o),  32'd1);
        check_val("rst_no_grant",  32'(bus.mem_en_o), 32'd0);
        mid_cycle();
        rst_n = 1'b1;

        // fetch 0x40, ready in first wait cycle
        post_edge();
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h2010_0005;
        mid_cycle();
        check_val("f_mem_en",   32'(bus.mem_en_o), 32'd1);
        check_val("f_mem_addr", bus.mem_addr_o,    32'h0000_0040);
        check_val("f_mem_we",   32'(bus.mem_we_o), 32'd0);
        check_val("f_ack_early", 32'(bus.if_ack_o), 32'd0);
        check_val("f_stall",    32'(bus.stall_o),  32'd1);
        post_edge();
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        mid_cycle();
        check_val("f_ack",      32'(bus.if_ack_o), 32'd1);
        check_val("f_rdata",    bus.if_rdata_o,    32'h2010_0005);
        check_val("f_done_en",  32'(bus.mem_en_o), 32'd0);
        check_val("f_err",      32'(bus.err_o),    32'd0);
        check_val("f_stall_ack", 32'(bus.stall_o), 32'd0);
        post_edge();
        bus.if_req_i = 1'b0;
        mid_cycle();
        check_val("f_ack_pulse", 32'(bus.if_ack_o), 32'd0);
        check_val("f_rdata_hold", bus.if_rdata_o,   32'h2010_0005);

        // simultaneous fetch and store: store first
        post_edge();
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0000_0080;
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h0000_0100;
        bus.dm_wdata_i = 32'hCAFE_F00D;
        mid_cycle();
        check_val("p_stall_req", 32'(bus.stall_o), 32'd1);
        post_edge();
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h7777_7777;
        mid_cycle();
        check_val("p_mem_we",   32'(bus.mem_we_o), 32'd1);
        check_val("p_mem_addr", bus.mem_addr_o,    32'h0000_0100);
        check_val("p_mem_wd",   bus.mem_wdata_o,   32'hCAFE_F00D);
        check_val("p_stall_w",  32'(bus.stall_o),  32'd1);
        post_edge();
        bus.mem_ready_i = 1'b0;
        mid_cycle();
        check_val("p_dm_ack",   32'(bus.dm_ack_o), 32'd1);
        check_val("p_if_noack", 32'(bus.if_ack_o), 32'd0);
        check_val("p_st_rdata", bus.dm_rdata_o,    32'd0);
        check_val("p_stall_d",  32'(bus.stall_o),  32'd1);
        post_edge();
        bus.dm_req_i = 1'b0;
        bus.dm_we_i  = 1'b0;
        mid_cycle();
        check_val("p_idle_en",  32'(bus.mem_en_o), 32'd0);
        check_val("p_stall_i",  32'(bus.stall_o),  32'd1);
        post_edge();
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'h1111_2222;
        mid_cycle();
        check_val("p_f_addr",   bus.mem_addr_o,    32'h0000_0080);
        check_val("p_f_we",     32'(bus.mem_we_o), 32'd0);
        check_val("p_stall_f",  32'(bus.stall_o),  32'd1);
        post_edge();
        bus.mem_ready_i = 1'b0;
        mid_cycle();
        check_val("p_if_ack",   32'(bus.if_ack_o), 32'd1);
        check_val("p_if_rdata", bus.if_rdata_o,    32'h1111_2222);
        post_edge();
        bus.if_req_i = 1'b0;

        // load 0x200, ready in sixth wait cycle
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h0000_0200;
        for (int i = 0; i < 6; i++) begin
            post_edge();
            if (i == 5) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_rdata_i = 32'h5A5A_0001;
            end
            mid_cycle();
            check_val($sformatf("l_en_%0d", i),   32'(bus.mem_en_o), 32'd1);
            check_val($sformatf("l_addr_%0d", i), bus.mem_addr_o,    32'h0000_0200);
            check_val($sformatf("l_we_%0d", i),   32'(bus.mem_we_o), 32'd0);
            check_val($sformatf("l_ack_%0d", i),  32'(bus.dm_ack_o), 32'd0);
        end
        post_edge();
        bus.mem_ready_i = 1'b0;
        mid_cycle();
        check_val("l_dm_ack",   32'(bus.dm_ack_o), 32'd1);
        check_val("l_err",      32'(bus.err_o),    32'd0);
        check_val("l_rdata",    bus.dm_rdata_o,    32'h5A5A_0001);
        post_edge();
        bus.dm_req_i = 1'b0;

        // load 0x300 that never gets ready: abort after 16 wait cycles
        post_edge();
        bus.dm_req_i  = 1'b1;
        bus.dm_addr_i = 32'h0000_0300;
        for (int i = 0; i < 16; i++) begin
            post_edge();
            mid_cycle();
            check_val($sformatf("t_en_%0d", i),  32'(bus.mem_en_o), 32'd1);
            check_val($sformatf("t_ack_%0d", i), 32'(bus.dm_ack_o), 32'd0);
        end
        post_edge();
        mid_cycle();
        check_val("t_dm_ack",   32'(bus.dm_ack_o), 32'd1);
        check_val("t_err",      32'(bus.err_o),    32'd1);
        check_val("t_rdata",    bus.dm_rdata_o,    ABORT_DATA);
        check_val("t_en_done",  32'(bus.mem_en_o), 32'd0);
        post_edge();
        bus.dm_req_i = 1'b0;
        mid_cycle();
        check_val("t_err_pulse", 32'(bus.err_o),   32'd0);

        // store 0x400 interrupted by reset mid-wait, then re-granted
        post_edge();
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h0000_0400;
        bus.dm_wdata_i = 32'h1234_5678;
        post_edge();
        mid_cycle();
        check_val("r_en_pre",   32'(bus.mem_en_o), 32'd1);
        check_val("r_we_pre",   32'(bus.mem_we_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("r_mem_en",   32'(bus.mem_en_o), 32'd0);
        check_val("r_mem_we",   32'(bus.mem_we_o), 32'd0);
        check_val("r_mem_addr", bus.mem_addr_o,    32'd0);
        check_val("r_mem_wd",   bus.mem_wdata_o,   32'd0);
        check_val("r_if_rd",    bus.if_rdata_o,    32'd0);
        check_val("r_stall",    32'(bus.stall_o),  32'd1);
        bus.mem_ready_i = 1'b1;
        repeat (2) begin
            post_edge();
            check_val("r_no_ack", 32'(bus.dm_ack_o), 32'd0);
        end
        bus.mem_ready_i = 1'b0;
        mid_cycle();
        rst_n = 1'b1;
        post_edge();
        bus.mem_ready_i = 1'b1;
        mid_cycle();
        check_val("r_regrant_en",   32'(bus.mem_en_o), 32'd1);
        check_val("r_regrant_addr", bus.mem_addr_o,    32'h0000_0400);
        check_val("r_regrant_wd",   bus.mem_wdata_o,   32'h1234_5678);
        post_edge();
        bus.mem_ready_i = 1'b0;
        mid_cycle();
        check_val("r_dm_ack",   32'(bus.dm_ack_o), 32'd1);
        check_val("r_err",      32'(bus.err_o),    32'd0);
        post_edge();
        bus.dm_req_i = 1'b0;
        bus.dm_we_i  = 1'b0;
        mid_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum memory wait cycles before abort, legal range 2..255.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset; asynchronous, active-low.
REQ-004 if_req_i  in  1  fetch request; if_addr_i  in  32  fetch byte address; both held stable until if_ack_o.
REQ-005 if_ack_o  out  1  one-cycle fetch completion pulse; if_rdata_o  out  32  fetched word, valid during if_ack_o.
REQ-006 dm_req_i  in  1  data request; dm_we_i  in  1  1=store; dm_addr_i  in  32; dm_wdata_i  in  32; all held stable until dm_ack_o.
REQ-007 dm_ack_o  out  1  one-cycle data completion pulse; dm_rdata_o  out  32  load data, valid during dm_ack_o.
REQ-008 mem_en_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32: single-port memory command.
REQ-009 mem_rdata_i  in  32; mem_ready_i  in  1  memory completion, sampled only while mem_en_o=1.
REQ-010 stall_o  out  1  pipeline freeze request; err_o  out  1  one-cycle timeout pulse, coincident with the aborted ack.

Function
REQ-011 States: IDLE, IF_WAIT, DM_WAIT, DONE; two-bit encoding.
REQ-012 IDLE: dm_req_i=1 -> DM_WAIT; else if_req_i=1 -> IF_WAIT; else stay; grant registers address, we, wdata and owner at the transition edge.
REQ-013 Simultaneous requests: data side always wins; fetch is granted from the next IDLE; no fairness counter.
REQ-014 In IF_WAIT/DM_WAIT: mem_en_o=1; mem_addr_o, mem_we_o, mem_wdata_o driven from the grant registers, constant for the whole wait; mem_we_o=0 for fetches.
REQ-015 WAIT with mem_ready_i=1 -> DONE; mem_rdata_i is captured into the owner's rdata register at that edge.
REQ-016 WAIT counter clears on grant and increments each WAIT cycle without ready; at TIMEOUT_CYC-1 without ready -> DONE with abort flag; captured rdata forced to 32'h0000_0000.
REQ-017 DONE: owner's ack_o=1 for exactly one cycle; err_o=1 if aborted; mem_en_o=0; unconditional -> IDLE; requests ignored in DONE.
REQ-018 The edge closing DONE is the edge at which the pipeline advances; req sampled in the following IDLE is a new transaction.
REQ-019 Minimum latency: grant edge to ack = 2 cycles (ready in first WAIT cycle); one transaction every 3 cycles.
REQ-020 rdata outputs hold their last captured value until the next capture for the same owner.
REQ-021 stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinational.
REQ-022 Store completions drive dm_rdata_o unchanged (no capture on mem_we_o=1).
REQ-023 A request dropped before ack is a protocol violation; behaviour is undefined, with no requirement to detect it.

Reset
REQ-024 rst_i=0 forces, immediately and including mid-transaction: state IDLE, counter 0, all grant and rdata registers 0, all outputs 0 except stall_o (combinational).
REQ-025 The first grant is possible at the first rising edge after rst_i deasserts.

Structure
REQ-026 Package mem_arb_pkg holds the state enum, TIMEOUT_CYC default, and ABORT_DATA constant (32'h0).
REQ-027 One sub-module, wait_timer: clear, enable, and terminal-count output; 8-bit counter.

Verification
REQ-028 if_req with addr 0x0000_0040 and ready on the first WAIT cycle -> mem_addr_o=0x40, mem_we_o=0, if_ack_o at grant+2, if_rdata_o = mem_rdata_i (0x2010_0005).
REQ-029 if_req and dm_req (store, 0x100, data 0xCAFE_F00D) both raised in the same cycle -> store served first (mem_we_o=1), dm_ack_o, then fetch granted, if_ack_o 3 cycles later; stall_o high throughout.
REQ-030 dm load at 0x200 with ready after 5 wait cycles -> mem outputs stable for all 6 WAIT cycles, dm_ack_o 1 cycle after ready, err_o=0.
REQ-031 dm load with mem_ready_i never asserted, TIMEOUT_CYC=16 -> DONE after 16 WAIT cycles, dm_ack_o=1, err_o=1, dm_rdata_o=0.
REQ-032 rst_i low during DM_WAIT -> all outputs 0 asynchronously, no ack; after release, the pending request is re-granted from IDLE.
